apb_clksw_regs: RTL and testbench
=================================

Name: apb_clksw_regs

Overview:
- APB3/APB4 register slave in the clk_apbs domain, directly downstream of the async APB bridge; consumes its s_* slave-side bus.
- Holds the clock-switch control and status registers, with programmable wait states.
- Runs a 4-phase req/ack handshake toward the glitch-free clock-switch core.
- Raises a maskable interrupt when a switch completes.

Parameters:
- WAIT_CYC, 1, wait states inserted in every access phase (0..15).
- ADDR_LSB_W, 12, number of decoded paddr bits; upper bits are ignored.
- SCRATCH_RST, 32'h0000_0000, reset value of the SCRATCH register.

Ports:
- clk_apbs  in  1  APB slave-side clock.
- rst_apbs  in  1  Asynchronous, active-high reset.
- s_psel  in  1  APB select.
- s_penable  in  1  APB enable.
- s_pwrite  in  1  1 = write.
- s_paddr  in  32  Byte address.
- s_pwdata  in  32  Write data.
- s_pprot  in  3  Protection; ignored except that it is captured to STATUS[6:4].
- s_pstrb  in  4  Byte write strobes.
- s_prdata  out  32  Read data.
- s_pready  out  1  Transfer complete.
- s_pslverr  out  1  Error response.
- clksw_req  out  1  Level request to the switch core.
- clksw_sel  out  2  Requested clock source, stable while clksw_req=1.
- clksw_ack  in  1  Level ack from the switch core (asynchronous).
- clksw_cur  in  2  Currently active source (asynchronous, quasi-static).
- irq  out  1  Level interrupt.

Behaviour:
- Clock/reset: one clock, clk_apbs. Reset rst_apbs is asynchronous and active-high. All flops clear on reset assertion.
- Reset values: s_prdata=0, s_pready=0 (when no access), s_pslverr=0, clksw_req=0, clksw_sel=0, irq=0, FSM=IDLE, wait counter=0.
- Access phase: s_psel & s_penable.
  - 4-bit wait counter increments each access cycle.
  - s_pready=1 when counter==WAIT_CYC; the counter then clears.
  - WAIT_CYC=0 gives a zero-wait-state transfer.
  - Outside an access phase, s_pready=0 and s_prdata=0.
- Register side effects happen only on the completion cycle (s_pready=1) and only when s_pslverr=0.
  - s_prdata and s_pslverr are meaningful only when s_pready=1; otherwise they are 0.
- Register map (offset, access, fields):
  - 0x00 CTRL, RW: [1:0] sel_req; [8] go (write-1 pulse, reads 0).
  - 0x04 STATUS, RO: [0] busy; [3:2] cur_sel (synchronised clksw_cur); [6:4] last pprot.
  - 0x08 SCRATCH, RW: 32 bits, byte-strobed.
  - 0x0C IRQ_STAT, W1C: [0] done.
  - 0x10 IRQ_EN, RW: [0] done_en.
- Strobes: bytes with s_pstrb[i]=0 are left unchanged on all RW registers.
- s_pslverr=1 on the completion cycle when any of these holds:
  - offset > 0x10;
  - s_paddr[1:0] != 0;
  - a write to STATUS;
  - a write to CTRL with go=1 while busy (in that case CTRL is left completely unchanged).
- Switch FSM:
  - IDLE: accepting a CTRL write with go=1 latches clksw_sel=sel_req and asserts clksw_req; go to REQ.
  - REQ: wait for ack_s=1, then drop clksw_req; go to REL.
  - REL: wait for ack_s=0; set IRQ_STAT.done; go to IDLE.
  - busy=1 in REQ and REL.
- ack_s: 2-flop synchroniser on clksw_ack. clksw_cur also uses a 2-flop synchroniser per bit.
- irq = IRQ_STAT.done & IRQ_EN.done_en, registered (1 cycle after the status bit sets).
- Simultaneous events: if done sets in the same cycle as a W1C clear of done, set wins.
- Reset mid-handshake: req drops immediately. The core must tolerate a req falling before ack; no recovery logic is required here.

Decomposition:
- Shared package apb_clksw_pkg holds:
  - register offset constants (CTRL_OFS, STATUS_OFS, SCRATCH_OFS, IRQ_STAT_OFS, IRQ_EN_OFS);
  - field bit positions;
  - FSM state enum (IDLE, REQ, REL).
- One sub-module, sync_2ff (parameterised width, async active-high reset), is used for clksw_ack and clksw_cur.

Test Plan:
- Reset, then read 0x04 with WAIT_CYC=1 and clksw_cur=2'b10 -> s_pready high on the 2nd access cycle, s_prdata=32'h0000_0008, s_pslverr=0.
- Write 0x08 with 32'hA5A5_1234 and pstrb=4'b0101, then read 0x08 -> 32'h00A5_0034.
- Write CTRL with 32'h0000_0101; core acks 3 cycles after req and releases 2 cycles after req falls -> clksw_sel=2'b01; busy=1 throughout; IRQ_STAT=1 at the end; irq=1 only when IRQ_EN=1.
- While busy, write CTRL with 32'h0000_0102 -> s_pslverr=1, clksw_sel stays 2'b01, no second request.
- Read 0x14, write 0x04, and read 0x0A -> s_pslverr=1 on each, no register changes.
- Assert rst_apbs during REQ -> clksw_req=0, FSM IDLE, and STATUS reads 0 in busy after release.

Source files
------------

// File: rtl/apb_clksw_pkg.sv
// Shared definitions for the APB clock-switch register slave: register
// offsets, field bit positions, switch FSM states and a byte-strobe helper.
// No ports; imported by apb_clksw_regs.
package apb_clksw_pkg;

  // Register offsets (byte addresses within the decoded window)
  localparam logic [31:0] CTRL_OFS     = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS   = 32'h0000_0004;
  localparam logic [31:0] SCRATCH_OFS  = 32'h0000_0008;
  localparam logic [31:0] IRQ_STAT_OFS = 32'h0000_000C;
  localparam logic [31:0] IRQ_EN_OFS   = 32'h0000_0010;

  // CTRL fields
  localparam int unsigned CTRL_SEL_LSB = 0;  // [1:0] sel_req
  localparam int unsigned CTRL_GO_BIT  = 8;  // write-1 pulse

  // STATUS fields
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_CUR_LSB  = 2;  // [3:2]
  localparam int unsigned STAT_PROT_LSB = 4;  // [6:4]

  // IRQ_STAT / IRQ_EN fields
  localparam int unsigned IRQ_DONE_BIT = 0;

  // Clock-switch handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } sw_state_e;

  // Merge new data into old data, byte by byte, where the strobe is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_clksw_regs_sync_2ff.sv
// Two-flop synchroniser for asynchronous level / quasi-static inputs.
// Ports: clk_i, rst_i (async, active-high), d_i (async in), q_o (synced out).
// Latency is two clk_i edges; each bit is synchronised independently.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/apb_clksw_regs.sv
// APB3/APB4 register slave holding clock-switch control/status, driving a
// 4-phase req/ack handshake to the glitch-free switch core, with a maskable
// completion interrupt.
// Ports: clk_apbs/rst_apbs; APB slave s_* (programmable wait states);
// clksw_req/clksw_sel/clksw_ack/clksw_cur toward the switch core; irq.
module apb_clksw_regs
  import apb_clksw_pkg::*;
#(
  parameter int unsigned WAIT_CYC    = 1,
  parameter int unsigned ADDR_LSB_W  = 12,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clk_apbs,
  input  logic        rst_apbs,
  // APB slave
  input  logic        s_psel,
  input  logic        s_penable,
  input  logic        s_pwrite,
  input  logic [31:0] s_paddr,
  input  logic [31:0] s_pwdata,
  input  logic [2:0]  s_pprot,
  input  logic [3:0]  s_pstrb,
  output logic [31:0] s_prdata,
  output logic        s_pready,
  output logic        s_pslverr,
  // Clock-switch core
  output logic        clksw_req,
  output logic [1:0]  clksw_sel,
  input  logic        clksw_ack,
  input  logic [1:0]  clksw_cur,
  // Interrupt
  output logic        irq
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYC);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  sel_req_q,  sel_req_d;
  logic [31:0] scratch_q,  scratch_d;
  logic        done_q,     done_d;
  logic        en_q,       en_d;
  logic [2:0]  prot_q,     prot_d;
  sw_state_e   state_q,    state_d;
  logic        req_q,      req_d;
  logic [1:0]  sel_q,      sel_d;
  logic        irq_q,      irq_d;

  // ---------------------------------------------------------------------
  // Synchronisers for the asynchronous core-side inputs
  // ---------------------------------------------------------------------
  logic       ack_s;
  logic [1:0] cur_s;

  sync_2ff #(.WIDTH(1)) u_sync_ack (
    .clk_i (clk_apbs),
    .rst_i (rst_apbs),
    .d_i   (clksw_ack),
    .q_o   (ack_s)
  );

  sync_2ff #(.WIDTH(2)) u_sync_cur (
    .clk_i (clk_apbs),
    .rst_i (rst_apbs),
    .d_i   (clksw_cur),
    .q_o   (cur_s)
  );

  // ---------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------
  logic [31:0] ofs;
  logic        acc;
  logic        done_cyc;
  logic        busy;
  logic        go_wr;
  logic        err;
  logic        commit;
  logic        wr_en;

  // Only the low ADDR_LSB_W address bits take part in decoding.
  always_comb begin
    ofs = '0;
    ofs[ADDR_LSB_W-1:0] = s_paddr[ADDR_LSB_W-1:0];
  end

  logic unused_paddr;
  assign unused_paddr = ^s_paddr[31:ADDR_LSB_W];

  assign acc      = s_psel & s_penable;
  assign done_cyc = acc & (wait_cnt_q == WAIT_LIM);
  assign busy     = (state_q != IDLE);

  // go only counts when its byte lane is actually written.
  assign go_wr = s_pwrite & (ofs == CTRL_OFS) & s_pstrb[1] & s_pwdata[CTRL_GO_BIT];

  assign err = (ofs > IRQ_EN_OFS)
             | (s_paddr[1:0] != 2'b00)
             | (s_pwrite & (ofs == STATUS_OFS))
             | (go_wr & busy);

  assign commit = done_cyc & ~err;
  assign wr_en  = commit & s_pwrite;

  // Wait counter: counts access cycles, clears on completion and whenever
  // the bus leaves the access phase.
  always_comb begin
    wait_cnt_d = '0;
    if (acc && !done_cyc) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (ofs)
      CTRL_OFS:     rdata[CTRL_SEL_LSB +: 2] = sel_req_q;  // go always reads 0
      STATUS_OFS: begin
        rdata[STAT_BUSY_BIT]      = busy;
        rdata[STAT_CUR_LSB +: 2]  = cur_s;
        rdata[STAT_PROT_LSB +: 3] = prot_q;
      end
      SCRATCH_OFS:  rdata = scratch_q;
      IRQ_STAT_OFS: rdata[IRQ_DONE_BIT] = done_q;
      IRQ_EN_OFS:   rdata[IRQ_DONE_BIT] = en_q;
      default:      rdata = '0;
    endcase
  end

  // Response outputs are only non-zero on the completion cycle.
  assign s_pready  = done_cyc;
  assign s_pslverr = done_cyc & err;
  assign s_prdata  = (commit && !s_pwrite) ? rdata : 32'h0;

  // ---------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------
  always_comb begin
    sel_req_d = sel_req_q;
    scratch_d = scratch_q;
    en_d      = en_q;
    prot_d    = prot_q;
    if (commit) prot_d = s_pprot;
    if (wr_en) begin
      case (ofs)
        CTRL_OFS:    if (s_pstrb[0]) sel_req_d = s_pwdata[CTRL_SEL_LSB +: 2];
        SCRATCH_OFS: scratch_d = apply_strb(scratch_q, s_pwdata, s_pstrb);
        IRQ_EN_OFS:  if (s_pstrb[0]) en_d = s_pwdata[IRQ_DONE_BIT];
        default:     ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Switch handshake FSM
  // ---------------------------------------------------------------------
  logic done_set;
  logic done_clr;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sel_d    = sel_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        // Use the sel_req value being written in the same access.
        if (wr_en && go_wr) begin
          sel_d   = sel_req_d;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // W1C clear of done loses against a simultaneous set.
  assign done_clr = wr_en & (ofs == IRQ_STAT_OFS) & s_pstrb[0] & s_pwdata[IRQ_DONE_BIT];
  assign done_d   = done_set | (done_q & ~done_clr);
  assign irq_d    = done_q & en_q;

  // ---------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_apbs or posedge rst_apbs) begin
    if (rst_apbs) begin
      wait_cnt_q <= '0;
      sel_req_q  <= '0;
      scratch_q  <= SCRATCH_RST;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      prot_q     <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      sel_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      sel_req_q  <= sel_req_d;
      scratch_q  <= scratch_d;
      done_q     <= done_d;
      en_q       <= en_d;
      prot_q     <= prot_d;
      state_q    <= state_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      irq_q      <= irq_d;
    end
  end

  assign clksw_req = req_q;
  assign clksw_sel = sel_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_apb_clksw_regs.sv
// Self-checking bench for apb_clksw_regs: directed vector table, hand-written
// handshake/reset sequences, and randomized accesses against a register model.
module tb_apb_clksw_regs;

  localparam int unsigned WAIT = 1;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        clksw_req;
  logic [1:0]  clksw_sel;
  logic        clksw_ack;
  logic [1:0]  clksw_cur;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  int req_rises = 0;

  apb_clksw_regs #(.WAIT_CYC(WAIT), .ADDR_LSB_W(12), .SCRATCH_RST(32'h0)) dut (
    .clk_apbs  (clk),
    .rst_apbs  (rst),
    .s_psel    (psel),
    .s_penable (penable),
    .s_pwrite  (pwrite),
    .s_paddr   (paddr),
    .s_pwdata  (pwdata),
    .s_pprot   (pprot),
    .s_pstrb   (pstrb),
    .s_prdata  (prdata),
    .s_pready  (pready),
    .s_pslverr (pslverr),
    .clksw_req (clksw_req),
    .clksw_sel (clksw_sel),
    .clksw_ack (clksw_ack),
    .clksw_cur (clksw_cur),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clksw_req) req_rises++;

  // Switch-core model: ack 3 cycles after req rises, release 2 after it falls.
  initial begin
    clksw_ack = 1'b0;
    forever begin
      wait (clksw_req === 1'b1);
      repeat (3) @(posedge clk);
      #1 clksw_ack = 1'b1;
      wait (clksw_req === 1'b0);
      repeat (2) @(posedge clk);
      #1 clksw_ack = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr,
                     output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
    pwdata = wd; pstrb = st; pprot = pr;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pready === 1'b1 || n > 40) break;
    end
    rd = prdata;
    er = pslverr;
    chk("pready_latency", 32'(n), 32'(WAIT + 1));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Polls STATUS until busy clears; returns the busy bit of the first poll.
  task automatic wait_idle(output logic first_busy, output int polls);
    logic [31:0] rd;
    logic        e;
    polls = 0;
    first_busy = 1'b0;
    do begin
      apb(1'b0, 32'h4, 32'h0, 4'h0, 3'h0, rd, e);
      if (polls == 0) first_busy = rd[0];
      polls++;
    end while (rd[0] === 1'b1 && polls < 40);
    chk("switch_completes", {31'b0, rd[0]}, 32'h0);
  endtask

  function automatic logic [31:0] strb_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[16];

  // Reference model state
  logic [31:0] m_scr;
  logic [1:0]  m_sel, m_cur;
  logic        m_en, m_done;
  logic [2:0]  m_prot;

  initial begin
    logic [31:0] rd, wd, a, e_rd, r;
    logic        er, e_err, fb, wr;
    logic [11:0] ofs;
    logic [3:0]  st;
    logic [2:0]  pr;
    int          polls, kind;

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pprot = 0; pstrb = 0; clksw_cur = 2'b10;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_req", {31'b0, clksw_req}, 32'h0);
    chk("rst_sel", {30'b0, clksw_sel}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    apb(1'b0, 32'h4, 32'h0, 4'h0, 3'h0, rd, er);
    chk("status_after_rst", rd, 32'h0000_0008);
    chk("status_after_rst_err", {31'b0, er}, 32'h0);

    // ---------------- directed table ----------------
    tbl[0]  = '{1'b1, 32'h0000_0008, 32'hA5A5_1234, 4'b0101, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h00A5_0034, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'h0, 1'b1};
    tbl[3]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF,    32'h0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_000A, 32'h0,         4'h0,    32'h0, 1'b1};
    tbl[5]  = '{1'b1, 32'h0000_000A, 32'hFFFF_FFFF, 4'hF,    32'h0, 1'b1};
    tbl[6]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h00A5_0034, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1010, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'hDEA5_BE34, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'h0, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0000, 32'h0000_0003, 4'b0001, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'h0000_0003, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0,    32'h0000_0008, 1'b0};
    tbl[13] = '{1'b0, 32'hFFFF_F004, 32'h0,         4'h0,    32'h0000_0008, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h0, 1'b0};
    tbl[15] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0,    32'h0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, 3'h0, rd, er);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].wr && !tbl[i].exp_err)
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end
    chk("no_req_yet", 32'(req_rises), 32'h0);

    // ---------------- full switch ----------------
    apb(1'b1, 32'h0, 32'h0000_0101, 4'hF, 3'h0, rd, er);
    chk("go_err", {31'b0, er}, 32'h0);
    chk("go_req", {31'b0, clksw_req}, 32'h1);
    chk("go_sel", {30'b0, clksw_sel}, 32'h1);
    wait_idle(fb, polls);
    chk("busy_during_switch", {31'b0, fb}, 32'h1);
    chk("sel_after_switch", {30'b0, clksw_sel}, 32'h1);
    chk("req_after_switch", {31'b0, clksw_req}, 32'h0);
    chk("one_request", 32'(req_rises), 32'h1);
    apb(1'b0, 32'hC, 32'h0, 4'h0, 3'h0, rd, er);
    chk("irq_stat_done", rd, 32'h1);
    chk("irq_masked", {31'b0, irq}, 32'h0);
    apb(1'b1, 32'h10, 32'h1, 4'h1, 3'h0, rd, er);
    @(negedge clk); @(negedge clk);
    chk("irq_enabled", {31'b0, irq}, 32'h1);
    apb(1'b1, 32'hC, 32'h1, 4'h1, 3'h0, rd, er);
    @(negedge clk); @(negedge clk);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    apb(1'b0, 32'hC, 32'h0, 4'h0, 3'h0, rd, er);
    chk("irq_stat_cleared", rd, 32'h0);

    // ---------------- go while busy ----------------
    apb(1'b1, 32'h0, 32'h0000_0101, 4'hF, 3'h0, rd, er);
    apb(1'b1, 32'h0, 32'h0000_0102, 4'hF, 3'h0, rd, er);
    chk("busy_go_err", {31'b0, er}, 32'h1);
    chk("busy_go_sel", {30'b0, clksw_sel}, 32'h1);
    wait_idle(fb, polls);
    chk("busy_go_one_more_req", 32'(req_rises), 32'h2);
    apb(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, rd, er);
    chk("ctrl_unchanged", rd, 32'h1);
    apb(1'b0, 32'hC, 32'h0, 4'h0, 3'h0, rd, er);
    chk("irq_stat_done2", rd, 32'h1);
    chk("irq_level2", {31'b0, irq}, 32'h1);

    // ---------------- reset during REQ ----------------
    apb(1'b1, 32'h0, 32'h0000_0103, 4'hF, 3'h0, rd, er);
    chk("req_before_rst", {31'b0, clksw_req}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("req_drops_in_rst", {31'b0, clksw_req}, 32'h0);
    chk("sel_clear_in_rst", {30'b0, clksw_sel}, 32'h0);
    chk("irq_clear_in_rst", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    apb(1'b0, 32'h4, 32'h0, 4'h0, 3'h0, rd, er);
    chk("status_after_mid_rst", rd, 32'h0000_0008);
    chk("no_req_after_rst", {31'b0, clksw_req}, 32'h0);

    // ---------------- randomized accesses vs model ----------------
    m_scr = 32'h0; m_sel = 2'b00; m_en = 1'b0; m_done = 1'b0; m_prot = 3'h0;
    m_cur = 2'b10;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 7);
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      pr   = 3'($urandom_range(0, 7));
      r    = $urandom;
      case (kind)
        0, 1, 2, 3, 4: a = 32'(kind * 4);
        5:             a = 32'h14 + 32'(4 * $urandom_range(0, 50));
        6:             a = (r & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
        default:       a = {r[31:12], 12'(4 * $urandom_range(0, 4))};
      endcase
      ofs = a[11:0];
      if (ofs == 12'h0) wd[8] = 1'b0;  // no switch requests in this phase

      e_err = (ofs > 12'h10) || (a[1:0] != 2'b00) || (wr && ofs == 12'h4);
      case (ofs)
        12'h000: e_rd = {30'b0, m_sel};
        12'h004: e_rd = {25'b0, m_prot, m_cur, 1'b0, 1'b0};
        12'h008: e_rd = m_scr;
        12'h00C: e_rd = {31'b0, m_done};
        12'h010: e_rd = {31'b0, m_en};
        default: e_rd = 32'h0;
      endcase

      apb(wr, a, wd, st, pr, rd, er);
      chk($sformatf("rnd%0d_err a=%h", i, a), {31'b0, er}, {31'b0, e_err});
      if (!wr && !e_err) chk($sformatf("rnd%0d_rd a=%h", i, a), rd, e_rd);

      if (!e_err) begin
        m_prot = pr;
        if (wr) begin
          case (ofs)
            12'h000: if (st[0]) m_sel = wd[1:0];
            12'h008: m_scr = strb_merge(m_scr, wd, st);
            12'h00C: if (st[0] && wd[0]) m_done = 1'b0;
            12'h010: if (st[0]) m_en = wd[0];
            default: ;
          endcase
        end
      end
      @(negedge clk); @(negedge clk);
      chk($sformatf("rnd%0d_irq", i), {31'b0, irq}, {31'b0, m_done & m_en});
      m_cur = 2'($urandom_range(0, 3));
      clksw_cur = m_cur;
    end
    chk("rnd_no_req", {31'b0, clksw_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
